// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Sticky overrun/frame error flags are cleared by clear_err.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     uart_read_en,
    input  logic                     clear_err,
    output logic [7:0]               rd_data,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     overrun,
    output logic                     frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [2:0]              idx, idx_n;
    logic [7:0]              shreg;
    logic                    rx_meta, rx_s;
    logic                    sample_bit, push, ferr_set;
    logic                    pop, full, wr_en;
    logic [AW-1:0]           wptr, rptr;
    logic [DEPTH-1:0][7:0]   mem;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        sample_bit = 1'b0;
        push       = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                cnt_n   = '0;
            end
            START: if (cnt == CNT_HALF) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end else cnt_n = cnt + 1'b1;
            DATA: if (cnt == CNT_LAST) begin
                cnt_n      = '0;
                sample_bit = 1'b1;
                if (idx == 3'd7) state_n = STOP;
                else             idx_n   = idx + 1'b1;
            end else cnt_n = cnt + 1'b1;
            STOP: if (cnt == CNT_LAST) begin
                cnt_n = '0;
                if (rx_s) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_set = 1'b1;
                    state_n  = WAIT_HIGH;
                end
            end else cnt_n = cnt + 1'b1;
            // a held-low line parks here so a break reports only one error
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            if (sample_bit) shreg[idx] <= rx_s;
        end
    end

    // a pop in the push cycle frees a slot even when full
    assign pop      = uart_read_en && rx_valid;
    assign full     = (rx_count == FULL_CNT);
    assign wr_en    = push && (!full || pop);
    assign rx_valid = (rx_count != '0);
    assign rd_data  = rx_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            // set beats clear when both land in the same cycle
            if (push && !wr_en)  overrun <= 1'b1;
            else if (clear_err)  overrun <= 1'b0;
            if (ferr_set)        frame_err <= 1'b1;
            else if (clear_err)  frame_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: serial frames are bit-banged on rx and the
// outputs are compared against a byte-queue model with sticky flags.
module tb_uart_rx_buffer;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, uart_read_en = 1'b0, clear_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid, overrun, frame_err;
    logic [2:0] rx_count;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] q[$];
    bit         m_ov = 1'b0, m_fe = 1'b0;

    uart_rx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .uart_read_en(uart_read_en),
        .clear_err(clear_err), .rd_data(rd_data), .rx_valid(rx_valid),
        .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // One frame of 10 bit times plus one bit time of idle.  pop_c/clr_c/rst_c
    // pick the cycle (relative to the start bit) for a one-cycle read, clear
    // or two-cycle reset; cycle 40 is the stop-bit sample cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int pop_c, input int clr_c, input int rst_c);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int c = 0; c < 44; c++) begin
            rx           = (c < 40) ? bits[c/CPB] : 1'b1;
            uart_read_en = (c == pop_c);
            clear_err    = (c == clr_c);
            reset        = (rst_c >= 0 && c >= rst_c && c < rst_c + 2);
            @(posedge clk); #1;
        end
        uart_read_en = 1'b0; clear_err = 1'b0; reset = 1'b0; rx = 1'b1;
        if (rst_c >= 0) begin
            q.delete(); m_ov = 1'b0; m_fe = 1'b0;
        end else begin
            if (clr_c >= 0) begin m_ov = 1'b0; m_fe = 1'b0; end
            if (pop_c >= 0 && q.size() > 0) void'(q.pop_front());
            if (!stop_ok)              m_fe = 1'b1;
            else if (q.size() < DEPTH) q.push_back(b);
            else                       m_ov = 1'b1;
        end
    endtask

    task automatic pulse_read();
        uart_read_en = 1'b1;
        @(posedge clk); #1;
        uart_read_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        m_ov = 1'b0; m_fe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", rx_count); end
        n_cmp++; if ({overrun, frame_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {overrun, frame_err}); end
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rd_data); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1, -1, -1, -1);
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", rd_data); end
        n_cmp++; if (rx_count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", rx_count); end
        pulse_read();
        n_cmp++; if ({rx_valid, rx_count} !== 4'b0_000) begin n_bad++; $display("FAIL single_pop: got valid %b count %0d want 0 0", rx_valid, rx_count); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if ({rx_valid, overrun, frame_err} !== 3'b000) begin n_bad++; $display("FAIL glitch_quiet: got valid/ov/fe %b want 000", {rx_valid, overrun, frame_err}); end
        send_frame(8'h3A, 1'b1, -1, -1, -1);
        n_cmp++; if (rd_data !== 8'h3A || rx_count !== 3'd1) begin n_bad++; $display("FAIL glitch_resync: got %h/%0d want 3a/1", rd_data, rx_count); end
        pulse_read();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1, -1);
        n_cmp++; if (rx_count !== 3'd4) begin n_bad++; $display("FAIL ovr_count: got %0d want 4", rx_count); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (rd_data !== 8'(i)) begin n_bad++; $display("FAIL ovr_read%0d: got %h want %h", i, rd_data, 8'(i)); end
            pulse_read();
        end
        pulse_read();
        n_cmp++; if ({rx_valid, rx_count} !== 4'b0_000) begin n_bad++; $display("FAIL empty_read_ignored: got valid %b count %0d want 0 0", rx_valid, rx_count); end
        pulse_clear();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, -1, -1, -1);
        n_cmp++; if (frame_err !== 1'b1 || rx_count !== 3'd0) begin n_bad++; $display("FAIL ferr_set: got fe %b count %0d want 1 0", frame_err, rx_count); end
        send_frame(8'h7E, 1'b1, -1, -1, -1);
        n_cmp++; if (rd_data !== 8'h7E || rx_count !== 3'd1) begin n_bad++; $display("FAIL ferr_next: got %h/%0d want 7e/1", rd_data, rx_count); end
        pulse_clear();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
        pulse_read();
    endtask

    task automatic test_break();
        rx = 1'b0;
        for (int c = 0; c < 120; c++) begin
            clear_err = (c == 50);
            @(posedge clk); #1;
            if (c == 45) begin
                n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL break_set: got %b want 1", frame_err); end
            end
        end
        clear_err = 1'b0;
        n_cmp++; if (frame_err !== 1'b0 || rx_count !== 3'd0) begin n_bad++; $display("FAIL break_once: got fe %b count %0d want 0 0", frame_err, rx_count); end
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL break_release: got %b want 0", frame_err); end
        m_fe = 1'b0;
    endtask

    task automatic test_full_simul();
        logic [7:0] last;
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, -1, -1, -1);
        send_frame(8'h55, 1'b1, 40, -1, -1);
        n_cmp++; if (rx_count !== 3'd4 || overrun !== 1'b0) begin n_bad++; $display("FAIL full_simul: got count %0d ov %b want 4 0", rx_count, overrun); end
        last = 8'h00;
        while (q.size() > 0) begin
            last = q[0];
            n_cmp++; if (rd_data !== q[0]) begin n_bad++; $display("FAIL full_simul_drain: got %h want %h", rd_data, q[0]); end
            pulse_read();
        end
        n_cmp++; if (last !== 8'h55) begin n_bad++; $display("FAIL full_simul_tail: got %h want 55", last); end
    endtask

    task automatic test_clear_set_wins();
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, -1, -1, -1);
        send_frame(8'hC3, 1'b1, -1, 40, -1);
        n_cmp++; if (overrun !== m_ov || rx_count !== 3'd4) begin n_bad++; $display("FAIL set_wins: got ov %b count %0d want %b 4", overrun, rx_count, m_ov); end
        pulse_clear();
        while (q.size() > 0) pulse_read();
    endtask

    task automatic test_empty_simul();
        send_frame(8'h9A, 1'b1, 40, -1, -1);
        n_cmp++; if (rx_count !== 3'd1 || rd_data !== 8'h9A) begin n_bad++; $display("FAIL empty_simul: got %0d/%h want 1/9a", rx_count, rd_data); end
        pulse_read();
    endtask

    task automatic test_random();
        int op;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 5)      send_frame(8'($urandom), (op != 5), -1, -1, -1);
            else if (op <= 8) begin
                if (q.size() > 0) begin
                    n_cmp++; if (rd_data !== q[0]) begin n_bad++; $display("FAIL rand_head it%0d: got %h want %h", it, rd_data, q[0]); end
                end
                pulse_read();
            end else          pulse_clear();
            n_cmp++;
            if (rx_count !== 3'(q.size()) || rx_valid !== (q.size() != 0) ||
                overrun !== m_ov || frame_err !== m_fe) begin
                n_bad++;
                $display("FAIL rand_state it%0d: got cnt %0d v %b ov %b fe %b want cnt %0d v %b ov %b fe %b",
                         it, rx_count, rx_valid, overrun, frame_err, q.size(), q.size() != 0, m_ov, m_fe);
            end
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h11, 1'b1, -1, -1, -1);
        send_frame(8'h22, 1'b0, -1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1, 17);
        n_cmp++; if ({rx_valid, rx_count} !== 4'b0_000) begin n_bad++; $display("FAIL rst_mid_count: got valid %b count %0d want 0 0", rx_valid, rx_count); end
        n_cmp++; if ({overrun, frame_err} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 00", {overrun, frame_err}); end
        send_frame(8'h12, 1'b1, -1, -1, -1);
        n_cmp++; if (rd_data !== 8'h12 || rx_count !== 3'd1) begin n_bad++; $display("FAIL rst_mid_next: got %h/%0d want 12/1", rd_data, rx_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_break();
        test_full_simul();
        test_clear_set_wins();
        test_empty_simul();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
